// File: rtl/udar_pkg.sv
// Shared types for the ultrasonic ranging stages: state encodings and default timing parameters.
// Pure declarations; no latency and no backpressure.
package udar_pkg;

    localparam int DIV_DEFAULT = 50;   // 1 us tick at 50 MHz
    localparam int W_DEFAULT   = 16;
    localparam int PRESC_W     = 16;   // wide enough for DIV up to 65535

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2,
        DONE      = 2'd3
    } meas_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an async line, with registered rise/fall pulses; level lags input by 2 clk,
// edges by 3 clk. No backpressure: edges are single-cycle pulses.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            level <= 1'b0;
            prev  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            meta  <= d;
            level <= meta;
            prev  <= level;
            rise  <= level & ~prev;
            fall  <= ~level & prev;
        end
    end

endmodule

// File: rtl/echo_meas.sv
// Measures echo high time in prescaled ticks with a timeout; valid 2 clk after echo_s falls.
// No backpressure: valid is a one-cycle pulse, start is ignored unless idle.
module echo_meas
    import udar_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT,
    parameter int W   = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         echo,
    input  logic [W-1:0] max_ticks,
    output logic         busy,
    output logic         valid,
    output logic [W-1:0] result,
    output logic         timeout_flag
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIV - 1);

    meas_state_t        state;
    logic [PRESC_W-1:0] presc;
    logic [W-1:0]       cnt;
    logic [W-1:0]       limit;
    logic               echo_s;
    logic               echo_rise;
    logic               echo_fall;
    logic               tick;

    sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (echo),
        .level (echo_s),
        .rise  (echo_rise),
        .fall  (echo_fall)
    );

    assign tick = (presc == PRESC_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            valid        <= 1'b0;
            result       <= '0;
            timeout_flag <= 1'b0;
            limit        <= '0;
            presc        <= '0;
            cnt          <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        limit <= max_ticks;
                        presc <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    // A rise pulse whose level already dropped is a one-cycle blip, not an echo.
                    if (echo_rise && echo_s) begin
                        presc <= '0;
                        cnt   <= '0;
                        state <= MEASURE;
                    end else if (cnt == limit) begin
                        result       <= '0;
                        timeout_flag <= 1'b1;
                        valid        <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end else begin
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) cnt <= cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (echo_fall) begin
                        // Credit the tick landing on this edge so N*DIV high cycles read as N.
                        result       <= (tick && cnt != limit) ? cnt + 1'b1 : cnt;
                        timeout_flag <= 1'b0;
                        valid        <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end else if (cnt == limit) begin
                        result       <= limit;
                        timeout_flag <= 1'b1;
                        valid        <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end else begin
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_echo_meas.sv
// Directed bench for echo_meas at DIV=4, W=16.
module tb_echo_meas;

    localparam int DIV = 4;
    localparam int W   = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         echo = 1'b0;
    logic [W-1:0] max_ticks = '0;
    logic         busy;
    logic         valid;
    logic [W-1:0] result;
    logic         timeout_flag;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    int n;
    int v0;
    bit got;

    echo_meas #(.DIV(DIV), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .echo         (echo),
        .max_ticks    (max_ticks),
        .busy         (busy),
        .valid        (valid),
        .result       (result),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (valid === 1'b1) vcount++;

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [W-1:0] m);
        start = 1'b1;
        max_ticks = m;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cnt, output bit seen);
        cnt = 0;
        seen = 1'b0;
        while (cnt < budget && !seen) begin
            cyc(1);
            cnt++;
            if (valid === 1'b1) seen = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        cyc(3);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_result", result, 0);
        chk("rst_timeout", timeout_flag, 0);
        rst_n = 1'b1;
        cyc(2);

        // Normal: rise 20 cycles after start, high 40 cycles -> 10 ticks
        v0 = vcount;
        pulse_start(100);
        chk("norm_busy", busy, 1);
        cyc(19);
        echo = 1'b1;
        cyc(40);
        echo = 1'b0;
        wait_valid(20, n, got);
        chk("norm_seen", got, 1);
        chk("norm_latency", n, 4);
        chk("norm_result", result, 10);
        chk("norm_timeout", timeout_flag, 0);
        chk("norm_busy_done", busy, 0);
        cyc(1);
        chk("norm_valid_1cyc", valid, 0);
        chk("norm_result_held", result, 10);
        cyc(10);
        chk("norm_one_valid", vcount - v0, 1);

        // No echo: limit 5 -> timeout about 20 cycles after start
        pulse_start(5);
        wait_valid(40, n, got);
        chk("noecho_seen", got, 1);
        chk("noecho_window", (n >= 19 && n <= 21), 1);
        chk("noecho_result", result, 0);
        chk("noecho_timeout", timeout_flag, 1);
        cyc(3);

        // Limit 0: done one cycle after entering WAIT_RISE
        pulse_start(0);
        wait_valid(10, n, got);
        chk("lim0_seen", got, 1);
        chk("lim0_latency", n, 1);
        chk("lim0_result", result, 0);
        chk("lim0_timeout", timeout_flag, 1);
        cyc(3);

        // Start during MEASURE with a small limit must be ignored: 16 cycles -> 4
        v0 = vcount;
        pulse_start(100);
        cyc(2);
        echo = 1'b1;
        cyc(6);
        start = 1'b1;
        max_ticks = 3;
        cyc(1);
        start = 1'b0;
        max_ticks = 100;
        cyc(9);
        echo = 1'b0;
        wait_valid(20, n, got);
        chk("ign_seen", got, 1);
        chk("ign_result", result, 4);
        chk("ign_timeout", timeout_flag, 0);
        cyc(10);
        chk("ign_one_valid", vcount - v0, 1);

        // Long echo: saturate at limit 8
        v0 = vcount;
        pulse_start(8);
        cyc(2);
        echo = 1'b1;
        wait_valid(60, n, got);
        chk("long_seen", got, 1);
        chk("long_result", result, 8);
        chk("long_timeout", timeout_flag, 1);
        cyc(150);
        echo = 1'b0;
        cyc(10);
        chk("long_one_valid", vcount - v0, 1);
        chk("long_idle_busy", busy, 0);

        // Echo already high at start is not a rise; the later 12-cycle pulse reads 3
        v0 = vcount;
        echo = 1'b1;
        cyc(4);
        pulse_start(100);
        cyc(10);
        chk("pre_busy", busy, 1);
        chk("pre_no_valid", vcount - v0, 0);
        echo = 1'b0;
        cyc(6);
        echo = 1'b1;
        cyc(12);
        echo = 1'b0;
        wait_valid(20, n, got);
        chk("pre_seen", got, 1);
        chk("pre_result", result, 3);
        chk("pre_timeout", timeout_flag, 0);
        cyc(3);

        // Fall coinciding with limit hit: normal end
        pulse_start(3);
        cyc(2);
        echo = 1'b1;
        cyc(13);
        echo = 1'b0;
        wait_valid(20, n, got);
        chk("tie_seen", got, 1);
        chk("tie_result", result, 3);
        chk("tie_timeout", timeout_flag, 0);
        cyc(3);

        // One cycle longer: limit wins
        pulse_start(3);
        cyc(2);
        echo = 1'b1;
        cyc(14);
        echo = 1'b0;
        wait_valid(20, n, got);
        chk("over_seen", got, 1);
        chk("over_result", result, 3);
        chk("over_timeout", timeout_flag, 1);
        cyc(3);

        // Reset mid-MEASURE aborts; restart right after release
        pulse_start(100);
        cyc(1);
        echo = 1'b1;
        cyc(10);
        v0 = vcount;
        rst_n = 1'b0;
        echo = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_timeout", timeout_flag, 0);
        cyc(2);
        rst_n = 1'b1;
        pulse_start(100);
        chk("restart_busy", busy, 1);
        cyc(20);
        chk("mid_rst_no_valid", vcount - v0, 0);
        echo = 1'b1;
        cyc(8);
        echo = 1'b0;
        wait_valid(20, n, got);
        chk("restart_seen", got, 1);
        chk("restart_result", result, 2);
        chk("restart_timeout", timeout_flag, 0);
        cyc(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
